// File: rtl/freq_meter_if.sv
// Result bus of the gated frequency meter: measured input in, count/strobe/overflow out.
interface freq_meter_if #(
  parameter int CNT_W = 24
);
  logic             sig_in;
  logic [CNT_W-1:0] freq;
  logic             valid;
  logic             overflow;

  modport master (
    input  sig_in,
    output freq,
    output valid,
    output overflow
  );

  modport slave (
    output sig_in,
    input  freq,
    input  valid,
    input  overflow
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks and publishes the count once per window.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  freq_meter_if.master meter
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   warm_q, warm_d;
  logic [CNT_W-1:0]       freq_q, freq_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic                   rise;
  logic                   last;
  logic                   at_max;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       pub;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], meter.sig_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    last    = (gate_q == GATE_LAST);
    at_max  = (cnt_q == CNT_MAX);
    cnt_inc = at_max ? CNT_MAX : cnt_q + CNT_W'(1);
    pub     = rise ? cnt_inc : cnt_q;

    gate_d  = last ? '0 : gate_q + GW'(1);
    cnt_d   = pub;
    sat_d   = sat_q | (rise & at_max);
    warm_d  = warm_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    // An edge on the closing cycle still belongs to the window being published.
    if (last) begin
      cnt_d  = '0;
      sat_d  = 1'b0;
      warm_d = 1'b0;
      if (!warm_q) begin
        freq_d  = pub;
        ovf_d   = sat_q | (rise & at_max);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      gate_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      warm_q  <= 1'b1;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      warm_q  <= warm_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign meter.freq     = freq_q;
  assign meter.valid    = valid_q;
  assign meter.overflow = ovf_q;

endmodule
